// File: rtl/td4_uart_loader.sv
// td4_uart_loader: receives a 16-instruction TD4 program over an 8N1 UART line
// and writes it, one {immediate, opcode} byte per address, into program memory.
// The CPU is held off while a load is pending or in progress.
module td4_uart_loader #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rx,
    output logic [3:0] mem_addr,
    output logic [3:0] mem_opcode,
    output logic [3:0] mem_immediate,
    output logic       mem_we,
    output logic       cpu_hold,
    output logic       done,
    output logic       err
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_WAIT_SYNC, L_LOAD, L_DONE} ld_state_t;

    // Receiver-to-loader handshake: byte_valid_q is high for exactly one cycle
    // and shift_q holds the received byte in that cycle. There is no ready;
    // the loader consumes or discards every byte the cycle it is offered.

    logic            rx_meta_q, rx_s_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            brk_q, brk_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err;
    logic            rx_hold;

    ld_state_t       ld_state_q, ld_state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      mem_addr_q, mem_addr_d;
    logic [3:0]      mem_op_q, mem_op_d;
    logic [3:0]      mem_imm_q, mem_imm_d;
    logic            mem_we_q, mem_we_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // The receiver only runs while the loader is armed.
    assign rx_hold = !enable || (ld_state_q == L_IDLE);

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver next state: mid-bit sampling, false-start rejection, and a
    // break guard after a framing error so a stuck-low line cannot re-trigger.
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        brk_d        = brk_q;
        byte_valid_d = 1'b0;
        frame_err    = 1'b0;
        if (rx_hold) begin
            rx_state_d = R_IDLE;
            clk_cnt_d  = '0;
            bit_cnt_d  = '0;
            brk_d      = 1'b0;
        end else begin
            case (rx_state_q)
                R_IDLE: begin
                    if (brk_q) begin
                        if (rx_s_q) brk_d = 1'b0;
                    end else if (!rx_s_q) begin
                        rx_state_d = R_START;
                        clk_cnt_d  = '0;
                        bit_cnt_d  = '0;
                    end
                end
                R_START: begin
                    if (clk_cnt_q == HALF_M1) begin
                        clk_cnt_d  = '0;
                        rx_state_d = rx_s_q ? R_IDLE : R_DATA;
                    end else begin
                        clk_cnt_d = clk_cnt_q + CNT_ONE;
                    end
                end
                R_DATA: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_d = '0;
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) rx_state_d = R_STOP;
                    end else begin
                        clk_cnt_d = clk_cnt_q + CNT_ONE;
                    end
                end
                R_STOP: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_d  = '0;
                        rx_state_d = R_IDLE;
                        if (rx_s_q) begin
                            byte_valid_d = 1'b1;
                        end else begin
                            frame_err = 1'b1;
                            brk_d     = 1'b1;
                        end
                    end else begin
                        clk_cnt_d = clk_cnt_q + CNT_ONE;
                    end
                end
                default: rx_state_d = R_IDLE;
            endcase
        end
    end

    // Loader next state: sync hunt, sequential memory writes, completion.
    // DONE is entered on the cycle of the 16th strobe so that done rises the
    // cycle after the write is visible on the memory port.
    always_comb begin
        ld_state_d = ld_state_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_op_d   = mem_op_q;
        mem_imm_d  = mem_imm_q;
        mem_we_d   = 1'b0;
        err_d      = err_q;
        if (!enable) begin
            ld_state_d = L_IDLE;
            cnt_d      = 4'd0;
        end else begin
            if (frame_err) err_d = 1'b1;
            case (ld_state_q)
                L_IDLE: begin
                    ld_state_d = L_WAIT_SYNC;
                    cnt_d      = 4'd0;
                end
                L_WAIT_SYNC: begin
                    if (byte_valid_q && (shift_q == SYNC_BYTE)) begin
                        ld_state_d = L_LOAD;
                        cnt_d      = 4'd0;
                        err_d      = 1'b0;
                    end
                end
                L_LOAD: begin
                    if (frame_err) begin
                        ld_state_d = L_WAIT_SYNC;
                        cnt_d      = 4'd0;
                    end else if (byte_valid_q) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = cnt_q;
                        mem_op_d   = shift_q[3:0];
                        mem_imm_d  = shift_q[7:4];
                        cnt_d      = cnt_q + 4'd1;
                    end else if (mem_we_q && (mem_addr_q == 4'hF)) begin
                        ld_state_d = L_DONE;
                    end
                end
                L_DONE: ld_state_d = L_DONE;
                default: ld_state_d = L_IDLE;
            endcase
        end
    end

    // Status outputs are registered images of the next loader state.
    always_comb begin
        cpu_hold_d = (ld_state_d == L_WAIT_SYNC) || (ld_state_d == L_LOAD);
        done_d     = (ld_state_d == L_DONE);
    end

    // All receiver and loader state; reset drops every output at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= R_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            brk_q        <= 1'b0;
            byte_valid_q <= 1'b0;
            ld_state_q   <= L_IDLE;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_op_q     <= '0;
            mem_imm_q    <= '0;
            mem_we_q     <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            brk_q        <= brk_d;
            byte_valid_q <= byte_valid_d;
            ld_state_q   <= ld_state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_op_q     <= mem_op_d;
            mem_imm_q    <= mem_imm_d;
            mem_we_q     <= mem_we_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_opcode    = mem_op_q;
    assign mem_immediate = mem_imm_q;
    assign mem_we        = mem_we_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_td4_uart_loader.sv
// Bench for td4_uart_loader: table vectors, directed corner sequences, and
// randomized byte streams checked against a byte-level model of the loader.
module tb_td4_uart_loader;

    localparam int C = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] mem_addr, mem_opcode, mem_immediate;
    logic       mem_we, cpu_hold, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    // write words are {addr, immediate, opcode} == {addr, byte}
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];

    int          cyc = 0, last_we_cyc = -1, done_rise_cyc = -1, hold_fall_cyc = -1;
    int          we_width_viol = 0, hold_viol = 0;
    logic        prev_we = 1'b0, prev_done = 1'b0, prev_hold = 1'b0;
    logic [11:0] prev_word = '0;

    td4_uart_loader #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .rx            (rx),
        .mem_addr      (mem_addr),
        .mem_opcode    (mem_opcode),
        .mem_immediate (mem_immediate),
        .mem_we        (mem_we),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .err           (err)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // write-port monitor, sampled away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_we) begin
            got_q.push_back({mem_addr, mem_immediate, mem_opcode});
            last_we_cyc = cyc;
            if (prev_we) we_width_viol++;
        end
        if (prev_we && rst_n && ({mem_addr, mem_immediate, mem_opcode} != prev_word)) hold_viol++;
        if (done && !prev_done) done_rise_cyc = cyc;
        if (!cpu_hold && prev_hold) hold_fall_cyc = cyc;
        prev_we   = mem_we;
        prev_done = done;
        prev_hold = cpu_hold;
        prev_word = {mem_addr, mem_immediate, mem_opcode};
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one 8N1 frame; stop_ok=0 sends a low stop bit, then the line recovers
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        rx = 1'b0;
        idle(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(C);
        end
        rx = stop_ok;
        idle(C);
        rx = 1'b1;
        idle(stop_ok ? gap : gap + C);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        rx     = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_writes(input string name);
        check({name, "_nwe"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_load(input logic [7:0] base);
        logic [7:0] b;
        send_byte(8'hA5, 1'b1, 0);
        for (int k = 0; k < 16; k++) begin
            b = base + 8'(k);
            send_byte(b, 1'b1, $urandom_range(0, 2));
            exp_q.push_back({4'(k), b});
        end
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        bit          b1_ok;
        int          n_we;
        logic [11:0] word;
        logic        err;
        logic        hold;
        logic        done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         viol;
        bit         found;
        int         mode, k, nb, sel;
        logic       merr;
        bit         ok;
        logic [7:0] b;

        vecs[0] = '{8'hA5, 8'h3C, 1'b1, 1, 12'h03C, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h12, 8'hA5, 1'b1, 0, 12'h000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 8'hA5, 1'b1, 1, 12'h0A5, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 8'h77, 1'b0, 0, 12'h000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 0, 12'h000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'hA5, 8'hF0, 1'b1, 1, 12'h0F0, 1'b0, 1'b1, 1'b0};

        // reset: outputs 0 while asserted and for 200 idle cycles after
        idle(3);
        check("reset_outputs", 32'({mem_addr, mem_opcode, mem_immediate, mem_we, cpu_hold, done, err}), 32'd0);
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({mem_addr, mem_opcode, mem_immediate, mem_we, cpu_hold, done, err} != '0) viol++;
        end
        check("idle_200_outputs", 32'(viol), 32'd0);

        // table vectors: two frames after enable
        for (int i = 0; i < 6; i++) begin
            do_reset();
            enable = 1'b1;
            idle(2);
            send_byte(vecs[i].b0, 1'b1, C);
            send_byte(vecs[i].b1, vecs[i].b1_ok, C);
            idle(4 * C);
            if (vecs[i].n_we == 1) exp_q.push_back(vecs[i].word);
            compare_writes($sformatf("vec%0d", i));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
            check($sformatf("vec%0d_hold", i), 32'(cpu_hold), 32'(vecs[i].hold));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
        end

        // full load with back-to-back frames
        do_reset();
        check("hold_before_enable", 32'(cpu_hold), 32'd0);
        enable = 1'b1;
        idle(1);
        check("hold_after_enable", 32'(cpu_hold), 32'd1);
        send_byte(8'hA5, 1'b1, 0);
        for (int j = 0; j < 16; j++) begin
            send_byte(8'h30 + 8'(j), 1'b1, 0);
            exp_q.push_back({4'(j), 4'h3, 4'(j)});
        end
        idle(4 * C);
        compare_writes("full");
        check("full_done", 32'(done), 32'd1);
        check("full_hold", 32'(cpu_hold), 32'd0);
        check("full_err", 32'(err), 32'd0);
        check("full_done_timing", 32'(done_rise_cyc), 32'(last_we_cyc + 1));
        check("full_hold_timing", 32'(hold_fall_cyc), 32'(last_we_cyc + 1));
        send_byte(8'h55, 1'b1, 2 * C);
        check("done_ignores_bytes", 32'(got_q.size()), 32'd0);
        check("done_holds", 32'(done), 32'd1);

        // sync filtering
        do_reset();
        enable = 1'b1;
        idle(2);
        send_byte(8'h12, 1'b1, C);
        send_byte(8'hFF, 1'b1, C);
        check("sync_no_early_we", 32'(got_q.size()), 32'd0);
        send_load(8'hC7);
        idle(4 * C);
        compare_writes("sync");
        check("sync_done", 32'(done), 32'd1);

        // framing error mid-load, then a clean reload
        do_reset();
        enable = 1'b1;
        idle(2);
        send_byte(8'hA5, 1'b1, C);
        for (int j = 0; j < 5; j++) begin
            send_byte(8'h50 + 8'(j), 1'b1, C);
            exp_q.push_back({4'(j), 8'h50 + 8'(j)});
        end
        send_byte(8'h66, 1'b0, C);
        idle(2 * C);
        compare_writes("ferr");
        check("ferr_err", 32'(err), 32'd1);
        check("ferr_hold", 32'(cpu_hold), 32'd1);
        check("ferr_done", 32'(done), 32'd0);
        send_load(8'h01);
        idle(4 * C);
        compare_writes("ferr_reload");
        check("ferr_reload_err", 32'(err), 32'd0);
        check("ferr_reload_done", 32'(done), 32'd1);

        // abort inside the 8th data byte
        do_reset();
        enable = 1'b1;
        idle(2);
        send_byte(8'hA5, 1'b1, C);
        for (int j = 0; j < 7; j++) begin
            send_byte(8'h90 + 8'(j), 1'b1, C);
            exp_q.push_back({4'(j), 8'h90 + 8'(j)});
        end
        fork
            send_byte(8'h47, 1'b1, C);
            begin
                idle(5 * C);
                enable = 1'b0;
            end
        join
        idle(4 * C);
        compare_writes("abort");
        check("abort_hold", 32'(cpu_hold), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        enable = 1'b1;
        idle(2);
        send_load(8'h80);
        idle(4 * C);
        compare_writes("abort_reload");
        check("abort_reload_done", 32'(done), 32'd1);

        // glitch rejection in WAIT_SYNC and in LOAD
        do_reset();
        enable = 1'b1;
        idle(2);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(4 * C);
        send_byte(8'hA5, 1'b1, C);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(14 * C);
        send_byte(8'h21, 1'b1, C);
        idle(4 * C);
        exp_q.push_back(12'h021);
        compare_writes("glitch");
        check("glitch_err", 32'(err), 32'd0);

        // reset while the write strobe is high
        do_reset();
        enable = 1'b1;
        idle(2);
        send_byte(8'hA5, 1'b1, C);
        found = 1'b0;
        fork
            send_byte(8'h5A, 1'b1, C);
            begin
                for (int i = 0; i < 20 * C; i++) begin
                    @(negedge clk);
                    if (mem_we) begin
                        found = 1'b1;
                        break;
                    end
                end
                if (found) begin
                    rst_n = 1'b0;
                    #1;
                    check("midrst_we", 32'(mem_we), 32'd0);
                    check("midrst_addr_data", 32'({mem_addr, mem_opcode, mem_immediate}), 32'd0);
                end
            end
        join
        check("midrst_we_seen", 32'(found), 32'd1);

        // randomized streams against a byte-level model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            enable = 1'b1;
            idle(2);
            mode = 0;
            k = 0;
            merr = 1'b0;
            nb = $urandom_range(24, 40);
            for (int j = 0; j < nb; j++) begin
                sel = $urandom_range(0, 99);
                ok = 1'b1;
                if (sel < 15) b = 8'hA5;
                else b = 8'($urandom_range(0, 255));
                if (sel >= 15 && sel < 20) ok = 1'b0;
                send_byte(b, ok, $urandom_range(0, 2 * C));
                if (!ok) begin
                    merr = 1'b1;
                    if (mode == 1) mode = 0;
                end else if (mode == 0) begin
                    if (b == 8'hA5) begin
                        mode = 1;
                        k = 0;
                        merr = 1'b0;
                    end
                end else if (mode == 1) begin
                    exp_q.push_back({4'(k), b});
                    k++;
                    if (k == 16) mode = 2;
                end
            end
            idle(4 * C);
            compare_writes($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_err", r), 32'(err), 32'(merr));
            check($sformatf("rnd%0d_hold", r), 32'(cpu_hold), 32'(mode != 2));
            check($sformatf("rnd%0d_done", r), 32'(done), 32'(mode == 2));
        end

        check("we_pulse_width", 32'(we_width_viol), 32'd0);
        check("we_data_hold", 32'(hold_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
